// File: rtl/traffic_pkg.sv
// Shared constants for the adaptive traffic-light controller: lane indices and
// default sensor-conditioning parameters used by the conditioner and the FSM.
package traffic_pkg;

  localparam int NUM_LANES = 4;

  localparam int LANE_NS1 = 0;
  localparam int LANE_NS2 = 1;
  localparam int LANE_EW1 = 2;
  localparam int LANE_EW2 = 3;

  localparam int DEB_CYCLES = 4;
  localparam int CNT_W      = 5;
  localparam int CONG_HI    = 8;
  localparam int CONG_LO    = 4;

endpackage

// File: rtl/sensor_debounce.sv
// One loop-detector input: 2-FF synchronizer, stability debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = traffic_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          level_d_reg;
  logic          rise_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      rise_reg    <= 1'b0;
    end else begin
      sync1_reg   <= raw;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      rise_reg    <= level_reg & ~level_d_reg;
      // The edge that would bring the counter to DEB_CYCLES flips the level instead.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level      = level_reg;
  assign rise_pulse = rise_reg;

endmodule

// File: rtl/lane_sensor_conditioner.sv
// Per-lane vehicle queue tracking: debounced arrival/departure events drive a
// saturating counter, a non-empty flag, a hysteretic congestion flag and a sticky overflow flag.
module lane_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int NUM_LANES  = traffic_pkg::NUM_LANES,
  parameter int DEB_CYCLES = traffic_pkg::DEB_CYCLES,
  parameter int CNT_W      = traffic_pkg::CNT_W,
  parameter int CONG_HI    = traffic_pkg::CONG_HI,
  parameter int CONG_LO    = traffic_pkg::CONG_LO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       arrive_raw,
  input  logic [NUM_LANES-1:0]       depart_raw,
  input  logic [NUM_LANES-1:0]       lane_clear,
  output logic [NUM_LANES-1:0]       S1,
  output logic [NUM_LANES-1:0]       S5,
  output logic [NUM_LANES*CNT_W-1:0] queue_count,
  output logic [NUM_LANES-1:0]       sat_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HI_TH   = CNT_W'(CONG_HI);
  localparam logic [CNT_W-1:0] LO_TH   = CNT_W'(CONG_LO);

  logic [NUM_LANES-1:0] arrive_ev;
  logic [NUM_LANES-1:0] depart_ev;
  logic [NUM_LANES-1:0] unused_arrive_level;
  logic [NUM_LANES-1:0] unused_depart_level;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arrive (
        .clk       (clk),
        .rst       (rst),
        .raw       (arrive_raw[gi]),
        .level     (unused_arrive_level[gi]),
        .rise_pulse(arrive_ev[gi])
      );

      sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_depart (
        .clk       (clk),
        .rst       (rst),
        .raw       (depart_raw[gi]),
        .level     (unused_depart_level[gi]),
        .rise_pulse(depart_ev[gi])
      );

      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;
      logic             s1_reg;
      logic             s5_reg;
      logic             s5_next;
      logic             sat_reg;
      logic             sat_next;

      // Simultaneous arrive+depart cancel out, so they never touch the count or the flag.
      always_comb begin
        count_next = count_reg;
        sat_next   = sat_reg;
        if (arrive_ev[gi] && !depart_ev[gi]) begin
          if (count_reg == CNT_MAX) begin
            sat_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else if (depart_ev[gi] && !arrive_ev[gi] && (count_reg != '0)) begin
          count_next = count_reg - 1'b1;
        end
        if (lane_clear[gi]) begin
          count_next = '0;
          sat_next   = 1'b0;
        end

        s5_next = s5_reg;
        if (count_next >= HI_TH) begin
          s5_next = 1'b1;
        end else if (count_next <= LO_TH) begin
          s5_next = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= '0;
          s1_reg    <= 1'b0;
          s5_reg    <= 1'b0;
          sat_reg   <= 1'b0;
        end else begin
          count_reg <= count_next;
          s1_reg    <= (count_next != '0);
          s5_reg    <= s5_next;
          sat_reg   <= sat_next;
        end
      end

      assign queue_count[gi*CNT_W +: CNT_W] = count_reg;
      assign S1[gi]       = s1_reg;
      assign S5[gi]       = s5_reg;
      assign sat_flag[gi] = sat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// Scoreboard bench: each driven event queues the expected lane state for the
// edge before and the edge at which the conditioner must reflect it.
module tb_lane_sensor_conditioner;
  import traffic_pkg::*;

  localparam int NL = NUM_LANES;
  localparam int CW = CNT_W;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] arrive_raw = '0;
  logic [NL-1:0] depart_raw = '0;
  logic [NL-1:0] lane_clear = '0;
  logic [NL-1:0] S1;
  logic [NL-1:0] S5;
  logic [NL*CW-1:0] queue_count;
  logic [NL-1:0] sat_flag;

  lane_sensor_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .arrive_raw (arrive_raw),
    .depart_raw (depart_raw),
    .lane_clear (lane_clear),
    .S1         (S1),
    .S5         (S5),
    .queue_count(queue_count),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int asserts = 0;
  int errors  = 0;

  int m_cnt[NL];
  bit m_s5[NL];
  bit m_sat[NL];

  typedef struct {
    int due;
    int lane;
    int count;
    bit s1;
    bit s5;
    bit sat;
  } exp_t;

  exp_t sb[$];

  task automatic check_value(input string tag, input int got, input int exp);
    asserts++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    string pfx;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      pfx = $sformatf("L%0d@%0d", e.lane, e.due);
      check_value({pfx, " count"}, int'(queue_count[e.lane*CW +: CW]), e.count);
      check_value({pfx, " S1"}, int'(S1[e.lane]), int'(e.s1));
      check_value({pfx, " S5"}, int'(S5[e.lane]), int'(e.s5));
      check_value({pfx, " sat"}, int'(sat_flag[e.lane]), int'(e.sat));
    end
  endtask

  task automatic expect_lane(input int due, input int lane);
    exp_t e;
    e.due   = due;
    e.lane  = lane;
    e.count = m_cnt[lane];
    e.s1    = (m_cnt[lane] != 0);
    e.s5    = m_s5[lane];
    e.sat   = m_sat[lane];
    sb.push_back(e);
  endtask

  function automatic void model_event(input int lane, input bit a, input bit d);
    if (a && !d) begin
      if (m_cnt[lane] == MAXC) m_sat[lane] = 1'b1;
      else m_cnt[lane] = m_cnt[lane] + 1;
    end else if (d && !a) begin
      if (m_cnt[lane] != 0) m_cnt[lane] = m_cnt[lane] - 1;
    end
    if (m_cnt[lane] >= CONG_HI) m_s5[lane] = 1'b1;
    else if (m_cnt[lane] <= CONG_LO) m_s5[lane] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_cnt[i] = 0;
      m_s5[i]  = 1'b0;
      m_sat[i] = 1'b0;
    end
  endfunction

  // Raw pulses rise right after an edge; the next edge is the first sampled one (t),
  // so the lane must still show the old state at t+6 and the new one at t+7.
  task automatic send(input logic [NL-1:0] am, input logic [NL-1:0] dm,
                      input int hi, input int lo);
    int t;
    t = cyc + 1;
    for (int i = 0; i < NL; i++)
      if (am[i] || dm[i]) expect_lane(t + 6, i);
    for (int i = 0; i < NL; i++)
      if (am[i] || dm[i]) begin
        model_event(i, am[i], dm[i]);
        expect_lane(t + 7, i);
      end
    $display("txn t=%0d arrive=%b depart=%b hi=%0d", t, am, dm, hi);
    arrive_raw = am;
    depart_raw = dm;
    repeat (hi) tick();
    arrive_raw = '0;
    depart_raw = '0;
    repeat (lo) tick();
  endtask

  initial begin
    model_reset();

    // Reset held 3 edges with idle inputs, then released.
    for (int c = 1; c <= 3; c++)
      for (int l = 0; l < NL; l++) expect_lane(c, l);
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 1; c <= 3; c++)
      for (int l = 0; l < NL; l++) expect_lane(cyc + c, l);
    repeat (4) tick();

    // Short glitch on lane 0 must be ignored.
    expect_lane(cyc + 8, 0);
    expect_lane(cyc + 12, 0);
    $display("txn t=%0d glitch lane0 3 cycles", cyc + 1);
    arrive_raw[0] = 1'b1;
    repeat (3) tick();
    arrive_raw[0] = 1'b0;
    repeat (12) tick();
    send(4'b0001, 4'b0000, 10, 8);

    // Lane 2 congestion hysteresis.
    repeat (8) send(4'b0100, 4'b0000, 6, 8);
    repeat (3) send(4'b0000, 4'b0100, 6, 8);
    send(4'b0000, 4'b0100, 6, 8);

    // Lane 1 saturation, then clear.
    repeat (MAXC) send(4'b0010, 4'b0000, 6, 8);
    send(4'b0010, 4'b0000, 6, 8);
    lane_clear = 4'b0010;
    m_cnt[1] = 0;
    m_s5[1]  = 1'b0;
    m_sat[1] = 1'b0;
    expect_lane(cyc + 1, 1);
    $display("txn t=%0d lane_clear=%b", cyc + 1, lane_clear);
    tick();
    lane_clear = '0;
    tick();

    // Lane 3: aligned arrive+depart, then underflow guard.
    repeat (5) send(4'b1000, 4'b0000, 6, 8);
    send(4'b1000, 4'b1000, 6, 8);
    repeat (5) send(4'b0000, 4'b1000, 6, 8);
    send(4'b0000, 4'b1000, 6, 8);

    // Lane 0 to 6, then reset mid-debounce with the raw input held high.
    repeat (5) send(4'b0001, 4'b0000, 6, 8);
    arrive_raw[0] = 1'b1;
    repeat (4) tick();
    model_reset();
    rst = 1'b1;
    for (int l = 0; l < NL; l++) expect_lane(cyc + 1, l);
    $display("txn t=%0d reset mid-debounce", cyc + 1);
    tick();
    tick();
    rst = 1'b0;
    begin
      int t;
      t = cyc + 1;
      expect_lane(t + 6, 0);
      model_event(0, 1'b1, 1'b0);
      expect_lane(t + 7, 0);
    end
    repeat (12) tick();
    arrive_raw[0] = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    check_value("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
